rect_plotter: RTL and testbench
===============================

# rect_plotter

Sequences the pixel writes for one moving 4×4 sprite on the 160×120 frame buffer. It sits between the motion datapath, which produces a new sprite position and colour once per frame, and the VGA adapter, which consumes one x/y/colour/plot write per clock. On each start request it erases the sprite at its previous position, then draws it at the new position. It raises a one-cycle `done` when the sequence is finished.

## Interface
Parameters:
- `SPR_W`, default 4: sprite width in pixels.
- `SPR_H`, default 4: sprite height in pixels.
- `SCREEN_W`, default 160: frame width; the x clip limit.
- `SCREEN_H`, default 120: frame height; the y clip limit.
- `COLOUR_W`, default 3: colour width.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: system clock (CLOCK_50 domain).
- `reset` in 1: synchronous, active-high.
- `start` in 1: request a new erase+draw sequence; sampled only in IDLE.
- `x_in` in 8: new sprite top-left x.
- `y_in` in 7: new sprite top-left y.
- `colour_in` in COLOUR_W: new sprite colour.
- `busy` out 1: a sequence is in progress.
- `done` out 1: one-cycle pulse when the sequence completes.
- `x` out 8: pixel x to the VGA adapter.
- `y` out 7: pixel y to the VGA adapter.
- `colour` out COLOUR_W: pixel colour to the VGA adapter.
- `plot` out 1: write strobe to the VGA adapter.

## Operation
- **States:** IDLE → ERASE → DRAW → DONE → IDLE.
- **IDLE, start=1:**
  - Latch `x_in`, `y_in` and `colour_in` into `new_x`, `new_y` and `new_col`.
  - Go to ERASE if the erase feature is compiled in and `prev_valid`=1; otherwise go to DRAW.
- **Scan order:** each pass walks `dy`=0..SPR_H-1 in the outer loop and `dx`=0..SPR_W-1 in the inner loop, one pixel per cycle, in raster order.
- **ERASE:** emits `x`=`prev_x`+`dx`, `y`=`prev_y`+`dy`, `colour`=0.
- **DRAW:** emits `x`=`new_x`+`dx`, `y`=`new_y`+`dy`, `colour`=`new_col`.
- **Sums:** both sums are computed 1 bit wider than the output.
- **Clipping:** if the x sum ≥ SCREEN_W or the y sum ≥ SCREEN_H, then `plot`=0 for that cycle. The cycle is still consumed, so pass length is constant. The `x` and `y` outputs carry the truncated sums.
- **Last pixel of a pass:** reached at `dx`=SPR_W-1 and `dy`=SPR_H-1; the counters then reset to 0 and the FSM advances.
- **DONE:**
  - `done`=1 for one cycle.
  - `prev_x`, `prev_y` ← `new_x`, `new_y`.
  - `prev_valid` ← 1.
  - Next state is IDLE.
- **Ignored starts:** `start` is ignored in ERASE, DRAW and DONE, and is not queued. Inputs are not re-read until the next accepted start.
- **Reset values** (assert at any time, including mid-pass):
  - State IDLE; counters 0; `prev_valid`=0.
  - `x`, `y`, `colour`, `plot`, `busy` and `done` are all 0.
  - After reset, the next sequence is draw-only.

## Timing
- **Registered outputs:** `x`, `y`, `colour`, `plot` and `done` are registered. Each lags the state/counter by one cycle.
- **Reference edge:** `start` is sampled at edge E0.
- **busy:** `busy`=1 from the cycle after E0 through the cycle carrying the last draw pixel.
- **Pixel cycles:** the first pixel appears in the cycle after E0+1.
  - Erase pixels occupy SPR_W·SPR_H consecutive cycles.
  - Draw pixels follow immediately with no gap.
- **Sequence length:** 2·SPR_W·SPR_H pixel cycles (32 at defaults) with erase, or SPR_W·SPR_H (16) draw-only.
- **done:** high in the cycle immediately after the last draw pixel. `busy`=0 in that cycle.
- **Earliest next start:** a new start is accepted at the earliest one cycle after `done`.
- **plot** is never high outside pixel cycles.

## Configuration
- Macro: `RECT_PLOTTER_ERASE_EN`.
- **Defined:** the ERASE pass runs whenever `prev_valid`=1, as described above.
- **Undefined:**
  - The ERASE state, `prev_x`, `prev_y` and `prev_valid` are not built.
  - Every sequence is draw-only, SPR_W·SPR_H cycles.
  - Everything else is unchanged; the caller clears the screen by other means.

## Structure
- **Shared package `rect_plotter_pkg`:**
  - Screen constants (160, 120).
  - Coordinate widths (8, 7).
  - `COLOUR_W`.
  - The FSM state enum (IDLE, ERASE, DRAW, DONE).
- **One sub-module, `rect_scan`:**
  - Holds the `dx`/`dy` raster counters.
  - Inputs: `clr` and `en`.
  - Outputs: `dx`, `dy`, and a combinational `last` flag.
  - The top FSM uses `last` for its transitions.

## Test plan
1. **First start, draw-only:** reset, then start with (10,20) and colour 3'b100 → 16 plot cycles, x=10..13 inner / y=20..23 outer, colour 100. Then `done` for one cycle. No erase pass.
2. **Second start, erase then draw:** start with (11,21) and colour 3'b010 → 16 erase cycles at x 10..13 / y 20..23 with colour 000, then 16 draw cycles at x 11..14 / y 21..24 with colour 010, then `done`. Total 32 plot cycles with no gap.
3. **Clipping:** from reset, start with (158,118) → 16 cycles; `plot`=1 only for (158,118), (159,118), (158,119) and (159,119). The other 12 cycles have `plot`=0. `done` timing is unchanged.
4. **Start while busy:** pulse `start` and change `x_in` to 50 during the DRAW pass → no effect on the pass. Exactly one `done`, and `prev_x` equals the originally latched x.
5. **Reset mid-pass:** assert `reset` during the 7th draw pixel → next cycle `plot`, `busy` and `done` are 0. The following start produces a draw-only sequence of 16 cycles.
6. **Macro undefined:** repeat scenario 2 with `RECT_PLOTTER_ERASE_EN` undefined → the second start yields only 16 draw cycles at x 11..14 / y 21..24, and no colour-000 writes.

Source files
------------

// File: rtl/rect_plotter_pkg.sv
// ============================================================================
//  Module      : rect_plotter_pkg
//  Description : Shared constants and types for the sprite plotter: screen
//                size, pixel coordinate widths, colour width, FSM state
//                encoding and a counter-width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rect_plotter_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int COLOUR_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ERASE = 2'd1,
        ST_DRAW  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Width of a counter covering 0..n-1; never less than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rect_plotter_if.sv
// ============================================================================
//  Module      : rect_plotter_if
//  Description : Request/pixel bus between the motion datapath, the sprite
//                plotter and the VGA adapter.
//                Request side : start, x_in, y_in, colour_in
//                Status side  : busy, done
//                Pixel side   : x, y, colour, plot
//                master = requester / pixel consumer, slave = plotter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rect_plotter_if #(
    parameter int COLOUR_W = 3
);
    import rect_plotter_pkg::*;

    logic                start;
    logic [X_W-1:0]      x_in;
    logic [Y_W-1:0]      y_in;
    logic [COLOUR_W-1:0] colour_in;
    logic                busy;
    logic                done;
    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic [COLOUR_W-1:0] colour;
    logic                plot;

    modport master (
        output start, x_in, y_in, colour_in,
        input  busy, done, x, y, colour, plot
    );

    modport slave (
        input  start, x_in, y_in, colour_in,
        output busy, done, x, y, colour, plot
    );

endinterface

`default_nettype wire

// File: rtl/rect_scan.sv
// ============================================================================
//  Module      : rect_scan
//  Description : Raster counters for one sprite pass. dx is the inner loop
//                (0..SPR_W-1), dy the outer loop (0..SPR_H-1). Both wrap to 0
//                after the last pixel so back-to-back passes need no clear.
//  Ports       : clk, rst  - clock, synchronous active-high reset
//                clr       - synchronous clear of both counters
//                en        - advance one pixel
//                dx, dy    - current pixel offset
//                last      - combinational: current pixel ends the pass
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rect_scan #(
    parameter int SPR_W = 4,
    parameter int SPR_H = 4,
    parameter int DX_W  = rect_plotter_pkg::cnt_width(SPR_W),
    parameter int DY_W  = rect_plotter_pkg::cnt_width(SPR_H)
) (
    input  wire logic            clk,
    input  wire logic            rst,
    input  wire logic            clr,
    input  wire logic            en,
    output logic [DX_W-1:0]      dx,
    output logic [DY_W-1:0]      dy,
    output logic                 last
);

    logic dx_end;
    logic dy_end;

    assign dx_end = (dx == DX_W'(SPR_W - 1));
    assign dy_end = (dy == DY_W'(SPR_H - 1));
    assign last   = dx_end && dy_end;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            dx <= '0;
            dy <= '0;
        end else if (en) begin
            if (dx_end) begin
                dx <= '0;
                dy <= dy_end ? '0 : dy + DY_W'(1);
            end else begin
                dx <= dx + DX_W'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/rect_plotter.sv
// ============================================================================
//  Module      : rect_plotter
//  Description : Sequences pixel writes for one moving sprite. On start it
//                optionally erases the sprite at its previous position
//                (colour 0), then draws it at the new position, one pixel
//                per clock, and pulses done for one cycle. Pixels falling off
//                the screen keep their cycle but have plot low.
//  Ports       : clk, reset - clock, synchronous active-high reset
//                bus        - rect_plotter_if.slave (request, status, pixel)
//  Config      : RECT_PLOTTER_ERASE_EN - when defined, builds the erase pass
//                and the previous-position registers. When undefined every
//                sequence is draw-only.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rect_plotter #(
    parameter int SPR_W    = 4,
    parameter int SPR_H    = 4,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int COLOUR_W = 3
) (
    input  wire logic      clk,
    input  wire logic      reset,
    rect_plotter_if.slave  bus
);
    import rect_plotter_pkg::*;

    localparam int DX_W = cnt_width(SPR_W);
    localparam int DY_W = cnt_width(SPR_H);

    state_t              state;
    state_t              state_next;

    logic [X_W-1:0]      new_x;
    logic [Y_W-1:0]      new_y;
    logic [COLOUR_W-1:0] new_col;

`ifdef RECT_PLOTTER_ERASE_EN
    logic [X_W-1:0]      prev_x;
    logic [Y_W-1:0]      prev_y;
    logic                prev_valid;
`endif

    logic [DX_W-1:0]     dx;
    logic [DY_W-1:0]     dy;
    logic                last;
    logic                scan_en;

    logic [X_W-1:0]      base_x;
    logic [Y_W-1:0]      base_y;
    logic [COLOUR_W-1:0] pix_col;
    logic                pix_on;
    logic [X_W:0]        sum_x;
    logic [Y_W:0]        sum_y;
    logic                in_bounds;

    logic [X_W-1:0]      x_q;
    logic [Y_W-1:0]      y_q;
    logic [COLOUR_W-1:0] colour_q;
    logic                plot_q;
    logic                done_q;

    assign scan_en = (state == ST_ERASE) || (state == ST_DRAW);

    rect_scan #(
        .SPR_W (SPR_W),
        .SPR_H (SPR_H),
        .DX_W  (DX_W),
        .DY_W  (DY_W)
    ) u_scan (
        .clk  (clk),
        .rst  (reset),
        .clr  (state == ST_IDLE),
        .en   (scan_en),
        .dx   (dx),
        .dy   (dy),
        .last (last)
    );

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
`ifdef RECT_PLOTTER_ERASE_EN
                    state_next = prev_valid ? ST_ERASE : ST_DRAW;
`else
                    state_next = ST_DRAW;
`endif
                end
            end
`ifdef RECT_PLOTTER_ERASE_EN
            ST_ERASE: if (last) state_next = ST_DRAW;
`endif
            ST_DRAW:  if (last) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Request latch and previous-position tracking
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            new_x   <= '0;
            new_y   <= '0;
            new_col <= '0;
        end else if ((state == ST_IDLE) && bus.start) begin
            new_x   <= bus.x_in;
            new_y   <= bus.y_in;
            new_col <= bus.colour_in;
        end
    end

`ifdef RECT_PLOTTER_ERASE_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_x     <= '0;
            prev_y     <= '0;
            prev_valid <= 1'b0;
        end else if (state == ST_DONE) begin
            prev_x     <= new_x;
            prev_y     <= new_y;
            prev_valid <= 1'b1;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Pixel address: sums carry one extra bit so an overflow past the
    // coordinate width is still seen as off-screen.
    // ------------------------------------------------------------------
    always_comb begin
        base_x  = new_x;
        base_y  = new_y;
        pix_col = new_col;
        pix_on  = (state == ST_DRAW);
`ifdef RECT_PLOTTER_ERASE_EN
        if (state == ST_ERASE) begin
            base_x  = prev_x;
            base_y  = prev_y;
            pix_col = '0;
            pix_on  = 1'b1;
        end
`endif
    end

    assign sum_x     = {1'b0, base_x} + (X_W + 1)'(dx);
    assign sum_y     = {1'b0, base_y} + (Y_W + 1)'(dy);
    assign in_bounds = (sum_x < (X_W + 1)'(SCREEN_W)) &&
                       (sum_y < (Y_W + 1)'(SCREEN_H));

    // Outputs are one cycle behind state/counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            x_q      <= pix_on ? sum_x[X_W-1:0] : '0;
            y_q      <= pix_on ? sum_y[Y_W-1:0] : '0;
            colour_q <= pix_on ? pix_col : '0;
            plot_q   <= pix_on && in_bounds;
            done_q   <= (state == ST_DONE);
        end
    end

    // DONE still carries the last draw pixel on the outputs, so it counts
    // as busy; the cycle after it (IDLE, done high) does not.
    assign bus.busy   = (state != ST_IDLE);
    assign bus.done   = done_q;
    assign bus.x      = x_q;
    assign bus.y      = y_q;
    assign bus.colour = colour_q;
    assign bus.plot   = plot_q;

endmodule

`default_nettype wire

// File: tb/tb_rect_plotter.sv
// ============================================================================
//  Module      : tb_rect_plotter
//  Description : Self-checking bench for rect_plotter. Expected pixels are
//                queued when a start is driven and popped as the plotter
//                emits them. Follows RECT_PLOTTER_ERASE_EN for whether an
//                erase pass is expected.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rect_plotter;

    typedef struct {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
        logic       p;
    } pix_t;

    localparam int NONE = 999;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    rect_plotter_if #(.COLOUR_W(3)) bus ();

    rect_plotter #(
        .SPR_W    (4),
        .SPR_H    (4),
        .SCREEN_W (160),
        .SCREEN_H (120),
        .COLOUR_W (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    pix_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    bit   m_prev_valid = 1'b0;
    int   m_prev_x     = 0;
    int   m_prev_y     = 0;

    // Reference pixel stream for one pass at (bx, by).
    task automatic push_pass(input int bx, input int by, input logic [2:0] col);
        pix_t e;
        int   xs;
        int   ys;
        for (int dy = 0; dy < 4; dy++) begin
            for (int dx = 0; dx < 4; dx++) begin
                xs  = bx + dx;
                ys  = by + dy;
                e.x = xs[7:0];
                e.y = ys[6:0];
                e.c = col;
                e.p = (xs < 160) && (ys < 120);
                exp_q.push_back(e);
            end
        end
    endtask

    // One start request and the whole resulting sequence. poke_di pulses
    // start with x_in=50 at that draw pixel; rst_di asserts reset at that
    // draw pixel and abandons the sequence.
    task automatic run_sequence(input int bx, input int by, input logic [2:0] col,
                                input int poke_di, input int rst_di);
        pix_t e;
        int   n;
        int   first_draw;
        @(negedge clk);
        bus.start     = 1'b1;
        bus.x_in      = 8'(bx);
        bus.y_in      = 7'(by);
        bus.colour_in = col;
`ifdef RECT_PLOTTER_ERASE_EN
        if (m_prev_valid) push_pass(m_prev_x, m_prev_y, 3'b000);
`endif
        push_pass(bx, by, col);
        n          = exp_q.size();
        first_draw = n - 16;

        @(negedge clk);
        bus.start = 1'b0;
        vectors++;
        if (bus.busy !== 1'b1 || bus.plot !== 1'b0 || bus.done !== 1'b0) begin
            miscompares++;
            $display("FAIL accept_cycle: busy=%b plot=%b done=%b, required busy=1 plot=0 done=0",
                     bus.busy, bus.plot, bus.done);
        end

        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            e = exp_q.pop_front();
            vectors++;
            if (bus.plot !== e.p) begin
                miscompares++;
                $display("FAIL pixel_plot[%0d]: got %b, required %b", i, bus.plot, e.p);
            end
            vectors++;
            if (bus.x !== e.x || bus.y !== e.y || bus.colour !== e.c) begin
                miscompares++;
                $display("FAIL pixel_xyc[%0d]: got (%0d,%0d,%b), required (%0d,%0d,%b)",
                         i, bus.x, bus.y, bus.colour, e.x, e.y, e.c);
            end
            vectors++;
            if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
                miscompares++;
                $display("FAIL pixel_status[%0d]: busy=%b done=%b, required busy=1 done=0",
                         i, bus.busy, bus.done);
            end
            if (i - first_draw == poke_di) begin
                bus.start = 1'b1;
                bus.x_in  = 8'd50;
            end
            if (i - first_draw == rst_di) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                vectors++;
                if (bus.plot !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
                    miscompares++;
                    $display("FAIL reset_mid_pass: plot=%b busy=%b done=%b, required all 0",
                             bus.plot, bus.busy, bus.done);
                end
                exp_q.delete();
                m_prev_valid = 1'b0;
                return;
            end
        end

        @(negedge clk);
        bus.start = 1'b0;
        vectors++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.plot !== 1'b0) begin
            miscompares++;
            $display("FAIL done_cycle: done=%b busy=%b plot=%b, required done=1 busy=0 plot=0",
                     bus.done, bus.busy, bus.plot);
        end
        m_prev_valid = 1'b1;
        m_prev_x     = bx;
        m_prev_y     = by;

        @(negedge clk);
        vectors++;
        if (bus.done !== 1'b0 || bus.plot !== 1'b0) begin
            miscompares++;
            $display("FAIL done_pulse_width: done=%b plot=%b, required done=0 plot=0",
                     bus.done, bus.plot);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset        = 1'b0;
        m_prev_valid = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        bus.start     = 1'b0;
        bus.x_in      = '0;
        bus.y_in      = '0;
        bus.colour_in = '0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({bus.x, bus.y, bus.colour, bus.plot, bus.busy, bus.done} !== 21'd0) begin
            miscompares++;
            $display("FAIL reset_state: x=%0d y=%0d colour=%b plot=%b busy=%b done=%b, required all 0",
                     bus.x, bus.y, bus.colour, bus.plot, bus.busy, bus.done);
        end
        reset        = 1'b0;
        m_prev_valid = 1'b0;
    endtask

    task automatic test_draw_only();
        run_sequence(10, 20, 3'b100, NONE, NONE);
    endtask

    task automatic test_erase_draw();
        run_sequence(11, 21, 3'b010, NONE, NONE);
    endtask

    task automatic test_clipping();
        apply_reset();
        run_sequence(158, 118, 3'b111, NONE, NONE);
    endtask

    task automatic test_start_while_busy();
        run_sequence(30, 40, 3'b011, 8, NONE);
        // Next sequence erases at the originally latched 30,40 (if built).
        run_sequence(31, 41, 3'b001, NONE, NONE);
    endtask

    task automatic test_reset_mid_pass();
        run_sequence(60, 70, 3'b101, NONE, 6);
        run_sequence(5, 6, 3'b110, NONE, NONE);
    endtask

    task automatic test_back_to_back();
        run_sequence(0, 0, 3'b001, NONE, NONE);
        run_sequence(156, 116, 3'b010, NONE, NONE);
        run_sequence(100, 50, 3'b100, NONE, NONE);
    endtask

    initial begin
        test_reset();
        test_draw_only();
        test_erase_draw();
        test_clipping();
        test_start_while_busy();
        test_reset_mid_pass();
        test_back_to_back();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Safety bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
